rom_stream_loader: RTL and testbench

- Boot-image loader that sits directly upstream of the Nios on-chip program memory.
- Accepts a byte stream (UART/flash reader), packs bytes into 32-bit little-endian words and writes them through the memory's debug write port.
- After writing, reads every word back and checks a running 32-bit sum.
- Holds the CPU off memory (cpu_hold) for the whole load/verify sequence.

---
 rtl/rom_loader_pkg.sv | 24 ++
 rtl/rom_stream_loader_if.sv | 30 +++
 rtl/rom_stream_loader_byte_packer.sv | 33 +++
 rtl/rom_stream_loader.sv | 153 +++++++++++++++
 tb/tb_rom_stream_loader.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_loader_pkg.sv
// rtl/rom_loader_pkg.sv - shared constants and state encoding for the boot-image loader
package rom_loader_pkg;

  localparam int DEFAULT_ADDR_W = 12;
  localparam int DEFAULT_DEPTH  = 2560;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RECV    = 3'd1,
    WRITE   = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    CHECK   = 3'd5,
    DONE    = 3'd6,
    ERROR   = 3'd7
  } state_e;

  // Legal word counts are 1..depth; anything else is rejected at start.
  function automatic logic count_ok(input logic [31:0] n, input int depth);
    return (n != 32'd0) && (n <= 32'(depth));
  endfunction

endpackage

// File: rtl/rom_stream_loader_if.sv
// rtl/rom_stream_loader_if.sv - byte stream in and program-memory debug port out
interface rom_stream_loader_if import rom_loader_pkg::*; #(
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic              mem_debugaccess;
  logic [3:0]        mem_byteenable;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata;

  // master is the loader; slave is the stream source plus memory side
  modport master (
    input  s_data, s_valid, mem_readdata,
    output s_ready, mem_address, mem_chipselect, mem_write,
           mem_debugaccess, mem_byteenable, mem_writedata
  );

  modport slave (
    output s_data, s_valid, mem_readdata,
    input  s_ready, mem_address, mem_chipselect, mem_write,
           mem_debugaccess, mem_byteenable, mem_writedata
  );

endinterface

// File: rtl/rom_stream_loader_byte_packer.sv
// rtl/rom_stream_loader_byte_packer.sv - packs accepted bytes little-endian into a 32-bit word
module rom_stream_loader_byte_packer import rom_loader_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0] byte_idx;
  logic [31:0]      lanes;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx <= '0;
      lanes    <= '0;
    end else if (clear) begin
      byte_idx <= '0;
    end else if (en) begin
      lanes[{byte_idx, 3'b000} +: 8] <= data;
      byte_idx                       <= byte_idx + IDX_W'(1);
    end
  end

  // Fires on the transfer that completes the word; the counter wraps to lane 0.
  assign word_valid = en && (byte_idx == IDX_W'(BYTES_PER_WORD - 1));
  assign word       = lanes;

endmodule

// File: rtl/rom_stream_loader.sv
// rtl/rom_stream_loader.sv - loads a byte stream into program memory, then verifies it by readback sum
module rom_stream_loader import rom_loader_pkg::*; #(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] load_words,
  rom_stream_loader_if.master bus,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       checksum
);

  localparam logic [2:0] S_IDLE    = IDLE;
  localparam logic [2:0] S_RECV    = RECV;
  localparam logic [2:0] S_WRITE   = WRITE;
  localparam logic [2:0] S_RD_ADDR = RD_ADDR;
  localparam logic [2:0] S_RD_DATA = RD_DATA;
  localparam logic [2:0] S_CHECK   = CHECK;
  localparam logic [2:0] S_DONE    = DONE;
  localparam logic [2:0] S_ERROR   = ERROR;

  logic [2:0]        state;
  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W-1:0] word_count;
  logic [ADDR_W-1:0] last_idx;
  logic [31:0]       rsum;
  logic [31:0]       packed_word;
  logic              word_valid;
  logic              take;
  logic              idle_like;
  logic              start_ok;
  logic              start_accept;

  assign idle_like    = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
  assign start_ok     = count_ok(32'(load_words), DEPTH);
  assign start_accept = start && idle_like && start_ok;
  assign take         = (state == S_RECV) && bus.s_valid;
  assign last_idx     = word_count - ADDR_W'(1);
  assign busy         = !idle_like;

  rom_stream_loader_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_accept),
    .en         (take),
    .data       (bus.s_data),
    .word       (packed_word),
    .word_valid (word_valid)
  );

  always_comb begin
    bus.s_ready         = 1'b0;
    bus.mem_chipselect  = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_debugaccess = 1'b0;
    bus.mem_address     = '0;
    bus.mem_writedata   = '0;
    case (state)
      S_RECV: bus.s_ready = 1'b1;
      S_WRITE: begin
        bus.mem_chipselect  = 1'b1;
        bus.mem_write       = 1'b1;
        bus.mem_debugaccess = 1'b1;
        bus.mem_address     = word_idx;
        bus.mem_writedata   = packed_word;
      end
      S_RD_ADDR: begin
        bus.mem_chipselect  = 1'b1;
        bus.mem_debugaccess = 1'b1;
        bus.mem_address     = word_idx;
      end
      default: ;
    endcase
  end

  assign bus.mem_byteenable = 4'hF;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      word_idx   <= '0;
      word_count <= '0;
      rsum       <= '0;
      checksum   <= '0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            if (start_ok) begin
              state      <= S_RECV;
              word_count <= load_words;
              word_idx   <= '0;
              rsum       <= '0;
              checksum   <= '0;
              cpu_hold   <= 1'b1;
              done       <= 1'b0;
              error      <= 1'b0;
            end else begin
              // Bad count never touches memory, so the CPU is not held.
              state <= S_ERROR;
              done  <= 1'b0;
              error <= 1'b1;
            end
          end
        end
        S_RECV: begin
          if (word_valid) state <= S_WRITE;
        end
        S_WRITE: begin
          checksum <= checksum + packed_word;
          if (word_idx == last_idx) begin
            word_idx <= '0;
            state    <= S_RD_ADDR;
          end else begin
            word_idx <= word_idx + ADDR_W'(1);
            state    <= S_RECV;
          end
        end
        S_RD_ADDR: state <= S_RD_DATA;
        S_RD_DATA: begin
          // Memory presents the word addressed during RD_ADDR.
          rsum <= rsum + bus.mem_readdata;
          if (word_idx == last_idx) begin
            state <= S_CHECK;
          end else begin
            word_idx <= word_idx + ADDR_W'(1);
            state    <= S_RD_ADDR;
          end
        end
        S_CHECK: begin
          cpu_hold <= 1'b0;
          if (rsum == checksum) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            error <= 1'b1;
            state <= S_ERROR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_stream_loader.sv
// tb/tb_rom_stream_loader.sv - scoreboard bench for rom_stream_loader with a behavioural program memory
module tb_rom_stream_loader;
  import rom_loader_pkg::*;

  localparam int AW = 12;
  localparam int DP = 2560;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] load_words;
  logic          cpu_hold, busy, done, error;
  logic [31:0]   checksum;

  rom_stream_loader_if #(.ADDR_W(AW)) bus ();

  rom_stream_loader #(.ADDR_W(AW), .DEPTH(DP)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .load_words (load_words),
    .bus        (bus),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [DP];
  logic [31:0] rdata_q = 32'd0;
  int          corrupt_addr = -1;

  assign bus.mem_readdata = rdata_q;

  always @(posedge clk) begin
    if (bus.mem_chipselect && int'(bus.mem_address) < DP) begin
      if (bus.mem_write && bus.mem_debugaccess)
        mem[bus.mem_address] <= bus.mem_writedata;
      else if (!bus.mem_write)
        rdata_q <= (int'(bus.mem_address) == corrupt_addr) ? 32'hDEADBEEF : mem[bus.mem_address];
    end
  end

  wr_t           exp_q[$];
  wr_t           mon_e;
  int            pass_cnt = 0;
  int            check_cnt = 0;
  int            wr_cnt = 0;
  int            cs_cnt = 0;
  logic [AW-1:0] last_wr_addr = '0;

  always @(negedge clk) begin
    if (bus.mem_chipselect) cs_cnt++;
    check_cnt++;
    if (cpu_hold !== busy) $display("FAIL hold_vs_busy: cpu_hold=%b busy=%b", cpu_hold, busy);
    else pass_cnt++;
    if (bus.mem_chipselect && bus.mem_write) begin
      wr_cnt++;
      last_wr_addr = bus.mem_address;
      check_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_write: addr=%0d data=%h, no write expected", bus.mem_address, bus.mem_writedata);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.mem_address !== mon_e.addr || bus.mem_writedata !== mon_e.data)
          $display("FAIL sb_write: got addr=%0d data=%h, want addr=%0d data=%h",
                   bus.mem_address, bus.mem_writedata, mon_e.addr, mon_e.data);
        else pass_cnt++;
      end
      check_cnt++;
      if (bus.s_ready !== 1'b0 || bus.mem_byteenable !== 4'hF || bus.mem_debugaccess !== 1'b1 || int'(bus.mem_address) >= DP)
        $display("FAIL write_strobe: s_ready=%b be=%h dbg=%b addr=%0d, want 0/f/1/<%0d",
                 bus.s_ready, bus.mem_byteenable, bus.mem_debugaccess, bus.mem_address, DP);
      else pass_cnt++;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    load_words = '0;
    bus.s_valid = 1'b0;
    bus.s_data = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_load(input int n);
    start = 1'b1;
    load_words = AW'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic stream(input logic [7:0] b[$], input bit toggle, input int budget);
    int idx = 0;
    int cyc = 0;
    bit take;
    while (idx < b.size() && cyc < budget) begin
      if (toggle && cyc[0]) begin
        bus.s_valid = 1'b0;
      end else begin
        bus.s_valid = 1'b1;
        bus.s_data = b[idx];
      end
      take = bus.s_valid && bus.s_ready;
      @(negedge clk);
      cyc++;
      if (take) idx++;
    end
    bus.s_valid = 1'b0;
    if (idx < b.size()) begin
      check_cnt++;
      $display("FAIL stream_timeout: accepted %0d of %0d bytes", idx, b.size());
    end
  endtask

  task automatic wait_end(input int budget);
    int c = 0;
    while (!(done || error) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check_cnt++;
    if (!(done || error)) $display("FAIL end_timeout: done=%b error=%b after %0d cycles", done, error, c);
    else pass_cnt++;
  endtask

  task automatic push_three(output logic [7:0] b[$]);
    b = {};
    for (int i = 1; i <= 12; i++) b.push_back(8'(i));
    exp_q.push_back({12'd0, 32'h04030201});
    exp_q.push_back({12'd1, 32'h08070605});
    exp_q.push_back({12'd2, 32'h0C0B0A09});
  endtask

  task automatic test_reset();
    do_reset();
    check_cnt++;
    if ({cpu_hold, busy, done, error, bus.s_ready, bus.mem_chipselect, bus.mem_write, bus.mem_debugaccess} !== 8'b0)
      $display("FAIL reset_ctrl: hold/busy/done/err/rdy/cs/wr/dbg=%b, want 00000000",
               {cpu_hold, busy, done, error, bus.s_ready, bus.mem_chipselect, bus.mem_write, bus.mem_debugaccess});
    else pass_cnt++;
    check_cnt++;
    if (checksum !== 32'd0 || bus.mem_address !== '0 || bus.mem_writedata !== 32'd0)
      $display("FAIL reset_data: checksum=%h addr=%0d wdata=%h, want 0", checksum, bus.mem_address, bus.mem_writedata);
    else pass_cnt++;
    check_cnt++;
    if (bus.mem_byteenable !== 4'hF) $display("FAIL reset_be: got %h want f", bus.mem_byteenable);
    else pass_cnt++;
  endtask

  task automatic test_load(input bit toggle);
    logic [7:0] b[$];
    for (int i = 0; i < 3; i++) mem[i] = 32'd0;
    push_three(b);
    start_load(3);
    check_cnt++;
    if (cpu_hold !== 1'b1 || busy !== 1'b1) $display("FAIL load_hold: cpu_hold=%b busy=%b want 1 1", cpu_hold, busy);
    else pass_cnt++;
    stream(b, toggle, 200);
    wait_end(100);
    check_cnt++;
    if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0)
      $display("FAIL load_status: done=%b error=%b hold=%b want 1 0 0", done, error, cpu_hold);
    else pass_cnt++;
    check_cnt++;
    if (checksum !== 32'h1815120F) $display("FAIL load_checksum: got %h want 1815120f", checksum);
    else pass_cnt++;
    check_cnt++;
    if (mem[0] !== 32'h04030201 || mem[1] !== 32'h08070605 || mem[2] !== 32'h0C0B0A09)
      $display("FAIL load_mem: got %h %h %h", mem[0], mem[1], mem[2]);
    else pass_cnt++;
    check_cnt++;
    if (exp_q.size() != 0) $display("FAIL load_missing_writes: %0d left, want 0", exp_q.size());
    else pass_cnt++;
    exp_q = {};
  endtask

  task automatic test_bad_count(input int n);
    int cs0 = cs_cnt;
    start_load(n);
    check_cnt++;
    if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b0 || busy !== 1'b0)
      $display("FAIL bad_count_%0d: error=%b done=%b hold=%b busy=%b want 1 0 0 0", n, error, done, cpu_hold, busy);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    check_cnt++;
    if (cs_cnt != cs0) $display("FAIL bad_count_cs_%0d: %0d chipselect cycles, want 0", n, cs_cnt - cs0);
    else pass_cnt++;
  endtask

  task automatic test_corrupt_readback();
    logic [7:0] b[$];
    push_three(b);
    corrupt_addr = 1;
    start_load(3);
    stream(b, 1'b0, 200);
    wait_end(100);
    corrupt_addr = -1;
    check_cnt++;
    if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b0)
      $display("FAIL corrupt_status: error=%b done=%b hold=%b want 1 0 0", error, done, cpu_hold);
    else pass_cnt++;
    check_cnt++;
    if (checksum !== 32'h1815120F) $display("FAIL corrupt_checksum: got %h want 1815120f", checksum);
    else pass_cnt++;
    exp_q = {};
  endtask

  task automatic test_reset_mid_recv();
    logic [7:0] b[$];
    int w0;
    for (int i = 0; i < 22; i++) b.push_back(8'(8'h40 + i));
    for (int k = 0; k < 5; k++) exp_q.push_back({AW'(k), b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]});
    w0 = wr_cnt;
    start_load(6);
    stream(b, 1'b0, 200);
    check_cnt++;
    if (busy !== 1'b1 || bus.s_ready !== 1'b1) $display("FAIL mid_state: busy=%b s_ready=%b want 1 1", busy, bus.s_ready);
    else pass_cnt++;
    reset = 1'b1;
    #1;
    check_cnt++;
    if ({cpu_hold, busy, done, error, bus.s_ready, bus.mem_chipselect} !== 6'b0 || checksum !== 32'd0 || bus.mem_byteenable !== 4'hF)
      $display("FAIL mid_reset_outputs: hold/busy/done/err/rdy/cs=%b checksum=%h be=%h",
               {cpu_hold, busy, done, error, bus.s_ready, bus.mem_chipselect}, checksum, bus.mem_byteenable);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_cnt++;
    if (wr_cnt - w0 != 5 || exp_q.size() != 0) $display("FAIL mid_writes: %0d writes, %0d pending, want 5 0", wr_cnt - w0, exp_q.size());
    else pass_cnt++;
    exp_q = {};
    b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    exp_q.push_back({12'd0, 32'hDDCCBBAA});
    start_load(1);
    stream(b, 1'b0, 50);
    wait_end(50);
    check_cnt++;
    if (done !== 1'b1 || checksum !== 32'hDDCCBBAA || last_wr_addr !== 12'd0)
      $display("FAIL mid_reload: done=%b checksum=%h addr=%0d want 1 ddccbbaa 0", done, checksum, last_wr_addr);
    else pass_cnt++;
    exp_q = {};
  endtask

  task automatic test_full_depth();
    logic [7:0]  b[$];
    logic [31:0] sum = 32'd0;
    logic [31:0] w;
    int          w0 = wr_cnt;
    for (int i = 0; i < DP; i++) begin
      w = 32'(i) * 32'h00010001 + 32'h01000000;
      sum += w;
      b.push_back(w[7:0]);
      b.push_back(w[15:8]);
      b.push_back(w[23:16]);
      b.push_back(w[31:24]);
      exp_q.push_back({AW'(i), w});
    end
    start_load(DP);
    stream(b, 1'b0, 20000);
    wait_end(8000);
    check_cnt++;
    if (done !== 1'b1 || error !== 1'b0) $display("FAIL full_status: done=%b error=%b want 1 0", done, error);
    else pass_cnt++;
    check_cnt++;
    if (last_wr_addr !== AW'(DP - 1) || wr_cnt - w0 != DP)
      $display("FAIL full_addr: last=%0d writes=%0d want %0d %0d", last_wr_addr, wr_cnt - w0, DP - 1, DP);
    else pass_cnt++;
    check_cnt++;
    if (checksum !== sum) $display("FAIL full_checksum: got %h want %h", checksum, sum);
    else pass_cnt++;
    exp_q = {};
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    load_words = '0;
    bus.s_valid = 1'b0;
    bus.s_data = 8'h00;
    test_reset();
    test_load(1'b0);
    test_load(1'b1);
    test_bad_count(0);
    test_bad_count(2561);
    test_corrupt_readback();
    test_reset_mid_recv();
    test_full_depth();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
